// File: rtl/alarm_bank_if.sv
// Bus bundle between the alarm bank and its surroundings: time inputs, front-panel/UART
// programming, ring control and readback. The master side drives programming and control.
interface alarm_bank_if #(
    parameter int IDX_W = 2
);
    logic             tick_1hz;
    logic [6:0]       Sec_in;
    logic [6:0]       Min_in;
    logic [6:0]       Hour_in;
    logic             set;
    logic [IDX_W-1:0] sel;
    logic             Less_in;
    logic             Middle_in;
    logic             Big_in;
    logic             en_toggle;
    logic             uart_sign;
    logic [6:0]       Less_uart;
    logic [6:0]       Middle_uart;
    logic [6:0]       Big_uart;
    logic             snooze;
    logic             stop;
    logic             music_out;
    logic [IDX_W-1:0] ring_id;
    logic             snoozed;
    logic [6:0]       Sec;
    logic [6:0]       Min;
    logic [6:0]       Hour;
    logic             en_out;

    modport master (
        output tick_1hz, Sec_in, Min_in, Hour_in, set, sel,
               Less_in, Middle_in, Big_in, en_toggle,
               uart_sign, Less_uart, Middle_uart, Big_uart, snooze, stop,
        input  music_out, ring_id, snoozed, Sec, Min, Hour, en_out
    );

    modport slave (
        input  tick_1hz, Sec_in, Min_in, Hour_in, set, sel,
               Less_in, Middle_in, Big_in, en_toggle,
               uart_sign, Less_uart, Middle_uart, Big_uart, snooze, stop,
        output music_out, ring_id, snoozed, Sec, Min, Hour, en_out
    );
endinterface

// File: rtl/alarm_bank.sv
// Multi-channel alarm: per-channel programmable time/enable, once-per-second match,
// ring with auto-timeout, snooze and stop.
module alarm_bank #(
    parameter int N_ALARM     = 4,
    parameter int IDX_W       = 2,
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300
) (
    input  logic         clk,
    input  logic         reset,
    alarm_bank_if.slave  bus
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RINGING = 2'd1;
    localparam logic [1:0] SNOOZED = 2'd2;

    localparam logic [7:0] RING_INIT = 8'(RING_SECS);
    localparam logic [9:0] SNZ_INIT  = 10'(SNOOZE_SECS);

    logic [6:0]         sec_q  [N_ALARM];
    logic [6:0]         min_q  [N_ALARM];
    logic [6:0]         hour_q [N_ALARM];
    logic [N_ALARM-1:0] en_q;

    logic [1:0]       state_q, state_d;
    logic [7:0]       ring_cnt_q, ring_cnt_d;
    logic [9:0]       snz_cnt_q, snz_cnt_d;
    logic [IDX_W-1:0] ring_id_q, ring_id_d;
    logic             music_q, snoozed_q;

    logic             sel_ok, prog, uart_ok, btn_one;
    logic             match_hit;
    logic [IDX_W-1:0] match_idx;

    assign sel_ok  = int'(bus.sel) < N_ALARM;
    assign prog    = bus.set && sel_ok;
    assign uart_ok = (bus.Less_uart <= 7'd59) && (bus.Middle_uart <= 7'd59) &&
                     (bus.Big_uart <= 7'd23);
    assign btn_one = $onehot({bus.Less_in, bus.Middle_in, bus.Big_in});

    // NOTE: the channel table is a handful of flops, so it takes the async reset like
    // any other state; a true RAM would be left unreset and cleared by logic instead.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_ALARM; i++) begin
                sec_q[i]  <= '0;
                min_q[i]  <= '0;
                hour_q[i] <= '0;
            end
            en_q <= '0;
        end else if (prog) begin
            if (bus.uart_sign) begin
                if (uart_ok) begin
                    sec_q[bus.sel]  <= bus.Less_uart;
                    min_q[bus.sel]  <= bus.Middle_uart;
                    hour_q[bus.sel] <= bus.Big_uart;
                end
            end else if (btn_one) begin
                if (bus.Less_in)
                    sec_q[bus.sel] <= (sec_q[bus.sel] == 7'd59) ? '0 : sec_q[bus.sel] + 7'd1;
                if (bus.Middle_in)
                    min_q[bus.sel] <= (min_q[bus.sel] == 7'd59) ? '0 : min_q[bus.sel] + 7'd1;
                if (bus.Big_in)
                    hour_q[bus.sel] <= (hour_q[bus.sel] == 7'd23) ? '0 : hour_q[bus.sel] + 7'd1;
            end
            if (bus.en_toggle) en_q[bus.sel] <= ~en_q[bus.sel];
        end
    end

    assign bus.Sec    = sel_ok ? sec_q[bus.sel]  : '0;
    assign bus.Min    = sel_ok ? min_q[bus.sel]  : '0;
    assign bus.Hour   = sel_ok ? hour_q[bus.sel] : '0;
    assign bus.en_out = sel_ok && en_q[bus.sel];

    // Scan downwards so the lowest matching channel is the one left in match_idx.
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        for (int k = N_ALARM - 1; k >= 0; k--) begin
            if (en_q[k] && sec_q[k] == bus.Sec_in && min_q[k] == bus.Min_in &&
                hour_q[k] == bus.Hour_in) begin
                match_hit = 1'b1;
                match_idx = IDX_W'(k);
            end
        end
    end

    // NOTE: every next-state value gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        ring_id_d  = ring_id_q;
        case (state_q)
            IDLE: begin
                if (bus.tick_1hz && match_hit) begin
                    state_d    = RINGING;
                    ring_id_d  = match_idx;
                    ring_cnt_d = RING_INIT;
                end
            end
            RINGING: begin
                if (bus.stop) begin
                    state_d    = IDLE;
                    ring_cnt_d = '0;
                end else if (bus.snooze) begin
                    state_d    = SNOOZED;
                    ring_cnt_d = '0;
                    snz_cnt_d  = SNZ_INIT;
                end else if (bus.tick_1hz) begin
                    ring_cnt_d = ring_cnt_q - 8'd1;
                    if (ring_cnt_d == '0) state_d = IDLE;
                end
            end
            SNOOZED: begin
                if (bus.stop) begin
                    state_d   = IDLE;
                    snz_cnt_d = '0;
                end else if (bus.tick_1hz) begin
                    snz_cnt_d = snz_cnt_q - 10'd1;
                    if (snz_cnt_d == '0) begin
                        state_d    = RINGING;
                        ring_cnt_d = RING_INIT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together
    // from values sampled before the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
            ring_id_q  <= '0;
            music_q    <= 1'b0;
            snoozed_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
            ring_id_q  <= ring_id_d;
            music_q    <= (state_d == RINGING);
            snoozed_q  <= (state_d == SNOOZED);
        end
    end

    assign bus.music_out = music_q;
    assign bus.snoozed   = snoozed_q;
    assign bus.ring_id   = ring_id_q;

endmodule

// File: tb/tb_alarm_bank.sv
// Self-checking bench for alarm_bank: directed scenarios plus randomized traffic
// compared against a seconds-remaining reference model.
module tb_alarm_bank;

    localparam int N_ALARM     = 4;
    localparam int IDX_W       = 2;
    localparam int RING_SECS   = 60;
    localparam int SNOOZE_SECS = 300;

    logic clk;
    logic rst_n;

    alarm_bank_if #(.IDX_W(IDX_W)) bus ();

    alarm_bank #(
        .N_ALARM(N_ALARM), .IDX_W(IDX_W), .RING_SECS(RING_SECS), .SNOOZE_SECS(SNOOZE_SECS)
    ) dut (
        .clk  (clk),
        .reset(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: channel fields as plain integers, ring/snooze as seconds remaining.
    int m_sec [N_ALARM];
    int m_min [N_ALARM];
    int m_hour[N_ALARM];
    bit m_en  [N_ALARM];
    int ring_left;
    int snooze_left;
    int m_id;
    int now_s;

    task automatic model_clear();
        for (int i = 0; i < N_ALARM; i++) begin
            m_sec[i] = 0; m_min[i] = 0; m_hour[i] = 0; m_en[i] = 0;
        end
        ring_left = 0; snooze_left = 0; m_id = 0;
    endtask

    task automatic model_step();
        int hit;
        hit = -1;
        if (bus.tick_1hz === 1'b1)
            for (int k = N_ALARM - 1; k >= 0; k--)
                if (m_en[k] && m_sec[k] == int'(bus.Sec_in) && m_min[k] == int'(bus.Min_in) &&
                    m_hour[k] == int'(bus.Hour_in)) hit = k;
        if (ring_left > 0) begin
            if (bus.stop) ring_left = 0;
            else if (bus.snooze) begin ring_left = 0; snooze_left = SNOOZE_SECS; end
            else if (bus.tick_1hz) ring_left--;
        end else if (snooze_left > 0) begin
            if (bus.stop) snooze_left = 0;
            else if (bus.tick_1hz) begin
                snooze_left--;
                if (snooze_left == 0) ring_left = RING_SECS;
            end
        end else if (hit >= 0) begin
            ring_left = RING_SECS;
            m_id = hit;
        end
        if (bus.set && int'(bus.sel) < N_ALARM) begin
            int s;
            s = int'(bus.sel);
            if (bus.uart_sign) begin
                if (bus.Less_uart <= 59 && bus.Middle_uart <= 59 && bus.Big_uart <= 23) begin
                    m_sec[s] = int'(bus.Less_uart);
                    m_min[s] = int'(bus.Middle_uart);
                    m_hour[s] = int'(bus.Big_uart);
                end
            end else if (int'(bus.Less_in) + int'(bus.Middle_in) + int'(bus.Big_in) == 1) begin
                if (bus.Less_in)   m_sec[s]  = (m_sec[s] + 1) % 60;
                if (bus.Middle_in) m_min[s]  = (m_min[s] + 1) % 60;
                if (bus.Big_in)    m_hour[s] = (m_hour[s] + 1) % 24;
            end
            if (bus.en_toggle) m_en[s] = !m_en[s];
        end
    endtask

    task automatic clear_inputs();
        bus.tick_1hz = 0; bus.Sec_in = '0; bus.Min_in = '0; bus.Hour_in = '0;
        bus.set = 0; bus.sel = '0; bus.Less_in = 0; bus.Middle_in = 0; bus.Big_in = 0;
        bus.en_toggle = 0; bus.uart_sign = 0; bus.Less_uart = '0; bus.Middle_uart = '0;
        bus.Big_uart = '0; bus.snooze = 0; bus.stop = 0;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic uart_load(input int s, input int h, input int m, input int sc);
        bus.set = 1; bus.sel = IDX_W'(s);
        bus.Big_uart = 7'(h); bus.Middle_uart = 7'(m); bus.Less_uart = 7'(sc);
        bus.uart_sign = 1;
        cycle();
        bus.uart_sign = 0;
    endtask

    task automatic press(input bit l, input bit m, input bit b);
        bus.Less_in = l; bus.Middle_in = m; bus.Big_in = b;
        cycle();
        bus.Less_in = 0; bus.Middle_in = 0; bus.Big_in = 0;
    endtask

    task automatic toggle_en(input int s);
        bus.set = 1; bus.sel = IDX_W'(s); bus.en_toggle = 1;
        cycle();
        bus.en_toggle = 0;
    endtask

    task automatic tick_next();
        now_s = (now_s + 1) % 86400;
        bus.Hour_in = 7'(now_s / 3600);
        bus.Min_in  = 7'((now_s / 60) % 60);
        bus.Sec_in  = 7'(now_s % 60);
        bus.tick_1hz = 1;
        cycle();
        bus.tick_1hz = 0;
        cycle();
    endtask

    task automatic pulse_stop();
        bus.stop = 1; cycle(); bus.stop = 0;
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        model_clear();
        now_s = 0;
        repeat (2) @(posedge clk);
        #1;
        release_reset();
        checks++;
        if (bus.music_out !== 1'b0 || bus.snoozed !== 1'b0 || bus.ring_id !== '0) begin
            errors++;
            $display("FAIL reset_ring got music=%b snoozed=%b id=%0d want 0/0/0",
                     bus.music_out, bus.snoozed, bus.ring_id);
        end
        for (int s = 0; s < N_ALARM; s++) begin
            bus.sel = IDX_W'(s);
            #1;
            checks++;
            if (bus.Sec !== 7'd0 || bus.Min !== 7'd0 || bus.Hour !== 7'd0 || bus.en_out !== 1'b0) begin
                errors++;
                $display("FAIL reset_chan%0d got %0d:%0d:%0d en=%b want 0:0:0 en=0",
                         s, bus.Hour, bus.Min, bus.Sec, bus.en_out);
            end
        end
    endtask

    task automatic test_program();
        uart_load(1, 7, 30, 0);
        toggle_en(1);
        for (int s = 0; s < N_ALARM; s++) begin
            bus.sel = IDX_W'(s);
            #1;
            checks++;
            if (s == 1) begin
                if (bus.Hour !== 7'd7 || bus.Min !== 7'd30 || bus.Sec !== 7'd0 || bus.en_out !== 1'b1) begin
                    errors++;
                    $display("FAIL program_ch1 got %0d:%0d:%0d en=%b want 7:30:0 en=1",
                             bus.Hour, bus.Min, bus.Sec, bus.en_out);
                end
            end else if (bus.Hour !== 7'd0 || bus.Min !== 7'd0 || bus.Sec !== 7'd0 || bus.en_out !== 1'b0) begin
                errors++;
                $display("FAIL program_other%0d got %0d:%0d:%0d en=%b want 0:0:0 en=0",
                         s, bus.Hour, bus.Min, bus.Sec, bus.en_out);
            end
        end
    endtask

    task automatic test_ring_timeout();
        now_s = 7 * 3600 + 29 * 60 + 59;
        tick_next();
        checks++;
        if (bus.music_out !== 1'b1 || bus.ring_id !== 2'd1 || bus.snoozed !== 1'b0) begin
            errors++;
            $display("FAIL ring_start got music=%b id=%0d snoozed=%b want 1/1/0",
                     bus.music_out, bus.ring_id, bus.snoozed);
        end
        for (int i = 1; i <= RING_SECS; i++) begin
            tick_next();
            checks++;
            if (bus.music_out !== (i < RING_SECS)) begin
                errors++;
                $display("FAIL ring_timeout tick %0d got music=%b want %b",
                         i, bus.music_out, (i < RING_SECS));
            end
        end
        checks++;
        if (bus.snoozed !== 1'b0) begin
            errors++;
            $display("FAIL ring_timeout_idle got snoozed=%b want 0", bus.snoozed);
        end
    endtask

    task automatic test_snooze();
        now_s = 7 * 3600 + 29 * 60 + 59;
        tick_next();
        bus.snooze = 1; cycle(); bus.snooze = 0;
        checks++;
        if (bus.music_out !== 1'b0 || bus.snoozed !== 1'b1) begin
            errors++;
            $display("FAIL snooze_enter got music=%b snoozed=%b want 0/1", bus.music_out, bus.snoozed);
        end
        for (int i = 1; i <= SNOOZE_SECS; i++) begin
            tick_next();
            checks++;
            if (bus.music_out !== (i == SNOOZE_SECS) || bus.snoozed !== (i < SNOOZE_SECS)) begin
                errors++;
                $display("FAIL snooze_count tick %0d got music=%b snoozed=%b", i, bus.music_out, bus.snoozed);
            end
        end
        checks++;
        if (bus.ring_id !== 2'd1) begin
            errors++;
            $display("FAIL snooze_reringid got %0d want 1", bus.ring_id);
        end
        pulse_stop();
        checks++;
        if (bus.music_out !== 1'b0 || bus.snoozed !== 1'b0) begin
            errors++;
            $display("FAIL snooze_stop got music=%b snoozed=%b want 0/0", bus.music_out, bus.snoozed);
        end
    endtask

    task automatic test_priority();
        uart_load(0, 12, 0, 0);
        toggle_en(0);
        uart_load(2, 12, 0, 0);
        toggle_en(2);
        now_s = 11 * 3600 + 59 * 60 + 59;
        tick_next();
        checks++;
        if (bus.music_out !== 1'b1 || bus.ring_id !== 2'd0) begin
            errors++;
            $display("FAIL priority got music=%b id=%0d want 1/0", bus.music_out, bus.ring_id);
        end
        tick_next();
        pulse_stop();
        checks++;
        if (bus.music_out !== 1'b0 || bus.ring_id !== 2'd0) begin
            errors++;
            $display("FAIL priority_stop got music=%b id=%0d want 0/0", bus.music_out, bus.ring_id);
        end
    endtask

    task automatic test_uart_buttons();
        int exp_h[6] = '{0, 23, 23, 23, 23, 0};
        int exp_m[6] = '{0, 59, 59, 59, 0, 0};
        int exp_s[6] = '{0, 59, 59, 0, 0, 0};
        for (int step = 0; step < 6; step++) begin
            case (step)
                0: begin uart_load(3, 5, 10, 60); uart_load(3, 24, 0, 0); end
                1: uart_load(3, 23, 59, 59);
                2: begin press(1, 1, 0); bus.set = 0; press(1, 0, 0); bus.set = 1; end
                3: press(1, 0, 0);
                4: press(0, 1, 0);
                default: press(0, 0, 1);
            endcase
            bus.sel = 2'd3;
            #1;
            checks++;
            if (bus.Hour !== 7'(exp_h[step]) || bus.Min !== 7'(exp_m[step]) || bus.Sec !== 7'(exp_s[step])) begin
                errors++;
                $display("FAIL prog_step%0d got %0d:%0d:%0d want %0d:%0d:%0d", step,
                         bus.Hour, bus.Min, bus.Sec, exp_h[step], exp_m[step], exp_s[step]);
            end
        end
    endtask

    task automatic test_disabled();
        uart_load(3, 3, 0, 0);
        now_s = 2 * 3600 + 59 * 60 + 59;
        tick_next();
        checks++;
        if (bus.music_out !== 1'b0) begin
            errors++;
            $display("FAIL disabled_noring got music=%b want 0", bus.music_out);
        end
        toggle_en(3);
        now_s = 2 * 3600 + 59 * 60 + 59;
        tick_next();
        checks++;
        if (bus.music_out !== 1'b1 || bus.ring_id !== 2'd3) begin
            errors++;
            $display("FAIL enabled_ring got music=%b id=%0d want 1/3", bus.music_out, bus.ring_id);
        end
        pulse_stop();
    endtask

    task automatic test_reset_mid_ring();
        now_s = 11 * 3600 + 59 * 60 + 59;
        tick_next();
        checks++;
        if (bus.music_out !== 1'b1) begin
            errors++;
            $display("FAIL midring_start got music=%b want 1", bus.music_out);
        end
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        checks++;
        if (bus.music_out !== 1'b0 || bus.snoozed !== 1'b0) begin
            errors++;
            $display("FAIL midring_async got music=%b snoozed=%b want 0/0", bus.music_out, bus.snoozed);
        end
        for (int s = 0; s < N_ALARM; s++) begin
            bus.sel = IDX_W'(s);
            #1;
            checks++;
            if (bus.en_out !== 1'b0 || bus.Hour !== 7'd0) begin
                errors++;
                $display("FAIL midring_chan%0d got en=%b hour=%0d want 0/0", s, bus.en_out, bus.Hour);
            end
        end
        release_reset();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            int op, k;
            clear_inputs();
            bus.set = ($urandom_range(0, 7) != 0);
            bus.sel = IDX_W'($urandom_range(0, N_ALARM - 1));
            op = $urandom_range(0, 9);
            case (op)
                0: begin
                    bus.uart_sign = 1;
                    bus.Big_uart = 7'($urandom_range(0, 23));
                    bus.Middle_uart = 7'($urandom_range(0, 59));
                    bus.Less_uart = 7'($urandom_range(0, 59));
                end
                1: begin
                    bus.uart_sign = 1;
                    bus.Big_uart = 7'($urandom_range(0, 30));
                    bus.Middle_uart = 7'($urandom_range(50, 70));
                    bus.Less_uart = 7'($urandom_range(50, 70));
                end
                2: bus.Less_in = 1;
                3: bus.Middle_in = 1;
                4: bus.Big_in = 1;
                5: begin bus.Less_in = 1; bus.Big_in = $urandom_range(0, 1); bus.Middle_in = !bus.Big_in; end
                6: bus.en_toggle = 1;
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) begin
                bus.tick_1hz = 1;
                k = $urandom_range(0, N_ALARM - 1);
                if ($urandom_range(0, 1) == 0) begin
                    bus.Hour_in = 7'(m_hour[k]); bus.Min_in = 7'(m_min[k]); bus.Sec_in = 7'(m_sec[k]);
                end else begin
                    bus.Hour_in = 7'($urandom_range(0, 23));
                    bus.Min_in = 7'($urandom_range(0, 59));
                    bus.Sec_in = 7'($urandom_range(0, 59));
                end
            end
            bus.stop   = ($urandom_range(0, 79) == 0);
            bus.snooze = ($urandom_range(0, 59) == 0);
            cycle();
            checks++;
            if (bus.music_out !== (ring_left > 0) || bus.snoozed !== (snooze_left > 0) ||
                bus.ring_id !== IDX_W'(m_id)) begin
                errors++;
                $display("FAIL rand_ring cyc %0d got music=%b snoozed=%b id=%0d want %b/%b/%0d", c,
                         bus.music_out, bus.snoozed, bus.ring_id, (ring_left > 0), (snooze_left > 0), m_id);
            end
            k = int'(bus.sel);
            checks++;
            if (bus.Hour !== 7'(m_hour[k]) || bus.Min !== 7'(m_min[k]) || bus.Sec !== 7'(m_sec[k]) ||
                bus.en_out !== m_en[k]) begin
                errors++;
                $display("FAIL rand_readback cyc %0d ch %0d got %0d:%0d:%0d en=%b want %0d:%0d:%0d en=%b",
                         c, k, bus.Hour, bus.Min, bus.Sec, bus.en_out, m_hour[k], m_min[k], m_sec[k], m_en[k]);
            end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_program();
        test_ring_timeout();
        test_snooze();
        test_priority();
        test_uart_buttons();
        test_disabled();
        test_reset_mid_ring();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
